// File: rtl/cache_writeback_if.sv
// -----------------------------------------------------------------------------
// cache_writeback_if
//
// Avalon-MM write-only master bundle used by the cache write-back engine.
//
// Signals:
//   avm_address     byte address of the word being written
//   avm_write       write request, held until accepted
//   avm_writedata   32-bit write data
//   avm_byteenable  byte lane enables (always all lanes for this engine)
//   avm_waitrequest slave stall; the request is accepted in the first cycle
//                   where avm_write=1 and avm_waitrequest=0
//
// Modports:
//   master  the write-back engine (drives request, samples waitrequest)
//   slave   the memory side / bus model
// -----------------------------------------------------------------------------
interface cache_writeback_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] avm_address;
  logic                  avm_write;
  logic [31:0]           avm_writedata;
  logic [3:0]            avm_byteenable;
  logic                  avm_waitrequest;

  modport master (
    output avm_address,
    output avm_write,
    output avm_writedata,
    output avm_byteenable,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_write,
    input  avm_writedata,
    input  avm_byteenable,
    output avm_waitrequest
  );
endinterface : cache_writeback_if

// File: rtl/cache_writeback.sv
// -----------------------------------------------------------------------------
// cache_writeback
//
// Write-back engine for one direct-mapped cache line. On an accepted start of
// a dirty line it walks the line word by word through the line store's
// combinational lookup port and issues one single-word Avalon write per word,
// strictly in order 0..N-1, then pulses done. A clean line completes in one
// cycle with no bus activity.
//
// Optional feature (compile-time macro WB_CLEAN_LINE_EN):
//   Adds a CLEAN state between the last write and DONE that pulses clrDirty
//   with clrTag = captured tag, so the top level can rewrite the line as
//   valid and clean. Without the macro the last write goes straight to DONE.
//
// Parameters:
//   CACHE_LINE_WIDTH  log2 of the line size in bytes (N = 2^(CLW-2) words)
//   TAG_WIDTH         tag bits, taken from the top of the address
//   ADDR_WIDTH        byte address width
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   start      write-back request, only looked at while idle
//   lineTag    tag of the line, captured on accepted start
//   lineIndex  set index of the line, captured on accepted start
//   lineDirty  dirty flag of the line, sampled on accepted start
//   busy       high from the cycle after accepted start through done
//   done       one-cycle completion pulse
//   lkupOff    byte offset of the current word to the line store
//   lkupData   word returned by the line store for lkupOff
//   avm        Avalon-MM master bundle (cache_writeback_if.master)
//   clrDirty   one-cycle "mark line clean" pulse       (WB_CLEAN_LINE_EN)
//   clrTag     tag to rewrite with the clean line      (WB_CLEAN_LINE_EN)
// -----------------------------------------------------------------------------
module cache_writeback #(
  parameter int  CACHE_LINE_WIDTH = 6,
  parameter int  TAG_WIDTH        = 20,
  parameter int  ADDR_WIDTH       = 32,
  localparam int INDEX_WIDTH      = ADDR_WIDTH - TAG_WIDTH - CACHE_LINE_WIDTH,
  localparam int WORD_CNT_WIDTH   = CACHE_LINE_WIDTH - 2
) (
  input  logic                        clk,
  input  logic                        rst,

  input  logic                        start,
  input  logic [TAG_WIDTH-1:0]        lineTag,
  input  logic [INDEX_WIDTH-1:0]      lineIndex,
  input  logic                        lineDirty,
  output logic                        busy,
  output logic                        done,

  output logic [CACHE_LINE_WIDTH-1:0] lkupOff,
  input  logic [31:0]                 lkupData,

  cache_writeback_if.master           avm
`ifdef WB_CLEAN_LINE_EN
  ,
  output logic                        clrDirty,
  output logic [TAG_WIDTH-1:0]        clrTag
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_CLEAN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [TAG_WIDTH-1:0]      tag_q;
  logic [INDEX_WIDTH-1:0]    index_q;
  logic [WORD_CNT_WIDTH-1:0] word_cnt_q;

  // FSM decode strobes for the datapath.
  logic capture;   // accept a dirty line: latch tag/index, restart at word 0
  logic load;      // present the current word on the bus
  logic accept;    // bus accepted the current word this cycle
  logic advance;   // move on to the next word

  // The last word is detected explicitly so the counter never wraps
  // inside a transfer.
  logic last_word;
  assign last_word = (word_cnt_q == {WORD_CNT_WIDTH{1'b1}});

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first; a path that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    load    = 1'b0;
    accept  = 1'b0;
    advance = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
`ifdef WB_CLEAN_LINE_EN
    clrDirty = 1'b0;
`endif

    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (lineDirty) begin
            capture = 1'b1;
            state_d = S_LOAD;
          end else begin
            // Nothing to write back: report completion straight away.
            state_d = S_DONE;
          end
        end
      end

      S_LOAD: begin
        load    = 1'b1;
        state_d = S_WRITE;
      end

      S_WRITE: begin
        if (!avm.avm_waitrequest) begin
          accept = 1'b1;
          if (last_word) begin
`ifdef WB_CLEAN_LINE_EN
            state_d = S_CLEAN;
`else
            state_d = S_DONE;
`endif
          end else begin
            advance = 1'b1;
            state_d = S_LOAD;
          end
        end
      end

      S_CLEAN: begin
`ifdef WB_CLEAN_LINE_EN
        clrDirty = 1'b1;
`endif
        state_d = S_DONE;
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Line context and word counter
  // ---------------------------------------------------------------------------
  // Tag and index are only written on an accepted start, so they cannot
  // change mid-transfer even if start is pulsed again.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q      <= '0;
      index_q    <= '0;
      word_cnt_q <= '0;
    end else begin
      if (capture) begin
        tag_q      <= lineTag;
        index_q    <= lineIndex;
        word_cnt_q <= '0;
      end else if (advance) begin
        word_cnt_q <= word_cnt_q + 1'b1;
      end
    end
  end

  assign lkupOff = {word_cnt_q, 2'b00};

  // ---------------------------------------------------------------------------
  // Avalon request registers
  // ---------------------------------------------------------------------------
  // Address and data are loaded once per word in LOAD and then left alone,
  // which keeps them stable for as long as the slave stalls. avm_write is
  // only cleared by an accepted transfer (or reset), never by a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      avm.avm_address   <= '0;
      avm.avm_writedata <= '0;
      avm.avm_write     <= 1'b0;
    end else begin
      if (load) begin
        avm.avm_address   <= {tag_q, index_q, word_cnt_q, 2'b00};
        avm.avm_writedata <= lkupData;
        avm.avm_write     <= 1'b1;
      end else if (accept) begin
        avm.avm_write     <= 1'b0;
      end
    end
  end

  // Whole-word writes only.
  assign avm.avm_byteenable = 4'b1111;

`ifdef WB_CLEAN_LINE_EN
  // The captured tag is only meaningful while clrDirty is high; it reads as
  // zero after reset.
  assign clrTag = tag_q;
`endif

endmodule : cache_writeback

// File: tb/tb_cache_writeback.sv
// -----------------------------------------------------------------------------
// tb_cache_writeback
//
// Self-checking bench for cache_writeback with default parameters
// (N = 16 words per line). A behavioural line store answers lookups, a
// task-driven bus model injects wait states, and expected addresses, data,
// write counts and completion latency are computed from the line contents,
// the captured tag/index and the number of stall cycles.
// Builds with or without WB_CLEAN_LINE_EN.
// -----------------------------------------------------------------------------
module tb_cache_writeback;

  localparam int N_WORDS = 16;
`ifdef WB_CLEAN_LINE_EN
  localparam int CLEAN_CYC = 1;
`else
  localparam int CLEAN_CYC = 0;
`endif

  typedef int stall_t[N_WORDS];

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [19:0] line_tag;
  logic [5:0]  line_index;
  logic        line_dirty;
  logic        busy;
  logic        done;
  logic [5:0]  lkup_off;
  logic [31:0] lkup_data;
`ifdef WB_CLEAN_LINE_EN
  logic        clr_dirty;
  logic [19:0] clr_tag;
`endif

  logic [31:0] line_mem [N_WORDS];

  int tests = 0;
  int fails = 0;

  cache_writeback_if #(.ADDR_WIDTH(32)) avm_if ();

  cache_writeback dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .lineTag   (line_tag),
    .lineIndex (line_index),
    .lineDirty (line_dirty),
    .busy      (busy),
    .done      (done),
    .lkupOff   (lkup_off),
    .lkupData  (lkup_data),
    .avm       (avm_if)
`ifdef WB_CLEAN_LINE_EN
    ,
    .clrDirty  (clr_dirty),
    .clrTag    (clr_tag)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural line store: combinational word lookup.
  assign lkup_data = line_mem[lkup_off[5:2]];

  function automatic logic [31:0] exp_addr(input logic [19:0] tag,
                                           input logic [5:0] idx, input int k);
    return (32'(tag) << 12) | (32'(idx) << 6) | 32'(k * 4);
  endfunction

  // ---------------------------------------------------------------------------
  // One write-back request, monitored cycle by cycle at the falling edge.
  // stalls[k] = wait cycles inserted on word k. pulse_start re-asserts start
  // with junk line info during the transfer.
  // ---------------------------------------------------------------------------
  task automatic run_line(input string name, input logic [19:0] tag,
                          input logic [5:0] idx, input logic dirty,
                          input stall_t stalls, input bit pulse_start);
    int cyc, done_cyc, done_cnt, nacc, waited, stall_sum;
    int write_cycles, busy_bad, stable_bad, exp_done, exp_writes, nchk;
    bit prev_stalled;
    logic [31:0] prev_addr, prev_data;
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
`ifdef WB_CLEAN_LINE_EN
    int clr_cnt, clr_cyc;
    logic [19:0] clr_tag_seen;
    clr_cnt = 0; clr_cyc = -1; clr_tag_seen = '0;
`endif
    done_cyc = -1; done_cnt = 0; nacc = 0; waited = 0; write_cycles = 0;
    busy_bad = 0; stable_bad = 0; prev_stalled = 1'b0;
    prev_addr = '0; prev_data = '0;
    stall_sum = 0;
    foreach (stalls[k]) stall_sum += stalls[k];

    @(negedge clk);
    line_tag = tag; line_index = idx; line_dirty = dirty; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    line_tag = 20'($urandom); line_index = 6'($urandom);
    line_dirty = 1'($urandom);

    for (cyc = 1; cyc <= 400; cyc++) begin
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (busy !== ((done_cyc < 0) || (cyc == done_cyc))) busy_bad++;
      if (prev_stalled && (avm_if.avm_write !== 1'b1 ||
          avm_if.avm_address !== prev_addr || avm_if.avm_writedata !== prev_data))
        stable_bad++;
`ifdef WB_CLEAN_LINE_EN
      if (clr_dirty) begin
        clr_cnt++; clr_cyc = cyc; clr_tag_seen = clr_tag;
      end
`endif
      if (avm_if.avm_write) begin
        write_cycles++;
        if (waited < ((nacc < N_WORDS) ? stalls[nacc] : 0)) begin
          avm_if.avm_waitrequest = 1'b1;
          waited++;
        end else begin
          avm_if.avm_waitrequest = 1'b0;
          got_addr.push_back(avm_if.avm_address);
          got_data.push_back(avm_if.avm_writedata);
          nacc++;
          waited = 0;
        end
      end else begin
        avm_if.avm_waitrequest = 1'($urandom);
      end
      prev_stalled = avm_if.avm_write && avm_if.avm_waitrequest;
      prev_addr = avm_if.avm_address;
      prev_data = avm_if.avm_writedata;

      if (pulse_start && cyc >= 2 && cyc <= 20 && (cyc % 3) == 0) begin
        start = 1'b1; line_dirty = 1'($urandom);
        line_tag = 20'($urandom); line_index = 6'($urandom);
      end else begin
        start = 1'b0;
      end

      if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
      @(negedge clk);
    end
    start = 1'b0;
    avm_if.avm_waitrequest = 1'b0;

    exp_done   = dirty ? (2 * N_WORDS + 1 + stall_sum + CLEAN_CYC) : 1;
    exp_writes = dirty ? N_WORDS : 0;

    tests++;
    if (done_cyc !== exp_done) begin
      fails++;
      $display("FAIL %s done_cycle: got %0d expected %0d", name, done_cyc, exp_done);
    end
    tests++;
    if (done_cnt !== 1) begin
      fails++;
      $display("FAIL %s done_count: got %0d expected 1", name, done_cnt);
    end
    tests++;
    if (nacc !== exp_writes) begin
      fails++;
      $display("FAIL %s write_count: got %0d expected %0d", name, nacc, exp_writes);
    end
    tests++;
    if (write_cycles !== (dirty ? N_WORDS + stall_sum : 0)) begin
      fails++;
      $display("FAIL %s avm_write_cycles: got %0d expected %0d", name,
               write_cycles, dirty ? N_WORDS + stall_sum : 0);
    end
    tests++;
    if (busy_bad !== 0) begin
      fails++;
      $display("FAIL %s busy_window: got %0d bad cycles expected 0", name, busy_bad);
    end
    tests++;
    if (stable_bad !== 0) begin
      fails++;
      $display("FAIL %s stall_stability: got %0d bad cycles expected 0", name, stable_bad);
    end
    nchk = (nacc < exp_writes) ? nacc : exp_writes;
    for (int k = 0; k < nchk; k++) begin
      tests++;
      if (got_addr[k] !== exp_addr(tag, idx, k) || got_data[k] !== line_mem[k]) begin
        fails++;
        $display("FAIL %s word%0d: got addr %h data %h expected addr %h data %h",
                 name, k, got_addr[k], got_data[k], exp_addr(tag, idx, k), line_mem[k]);
      end
    end
`ifdef WB_CLEAN_LINE_EN
    tests++;
    if (clr_cnt !== (dirty ? 1 : 0)) begin
      fails++;
      $display("FAIL %s clrDirty_count: got %0d expected %0d", name, clr_cnt, dirty ? 1 : 0);
    end
    if (dirty) begin
      tests++;
      if (clr_cyc !== exp_done - 1 || clr_tag_seen !== tag) begin
        fails++;
        $display("FAIL %s clrDirty: got cycle %0d tag %h expected cycle %0d tag %h",
                 name, clr_cyc, clr_tag_seen, exp_done - 1, tag);
      end
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; line_tag = '0; line_index = '0; line_dirty = 1'b0;
    avm_if.avm_waitrequest = 1'b0;
    foreach (line_mem[k]) line_mem[k] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      avm_if.avm_waitrequest = 1'($urandom);
      tests++;
      if (busy !== 1'b0 || done !== 1'b0 || avm_if.avm_write !== 1'b0) begin
        fails++;
        $display("FAIL reset_ctrl c%0d: got busy %b done %b write %b expected 0 0 0",
                 c, busy, done, avm_if.avm_write);
      end
      tests++;
      if (avm_if.avm_address !== 32'h0 || avm_if.avm_writedata !== 32'h0 ||
          lkup_off !== 6'h0) begin
        fails++;
        $display("FAIL reset_data c%0d: got addr %h data %h off %h expected zeros",
                 c, avm_if.avm_address, avm_if.avm_writedata, lkup_off);
      end
      tests++;
      if (avm_if.avm_byteenable !== 4'hF) begin
        fails++;
        $display("FAIL reset_byteenable c%0d: got %h expected f", c, avm_if.avm_byteenable);
      end
`ifdef WB_CLEAN_LINE_EN
      tests++;
      if (clr_dirty !== 1'b0 || clr_tag !== 20'h0) begin
        fails++;
        $display("FAIL reset_clr c%0d: got %b %h expected 0 00000", c, clr_dirty, clr_tag);
      end
`endif
    end
    avm_if.avm_waitrequest = 1'b0;
  endtask

  task automatic test_dirty_line();
    stall_t st = '{default: 0};
    foreach (line_mem[k]) line_mem[k] = 32'(k) * 32'h1111_1111;
    run_line("dirty_line", 20'hABCDE, 6'h05, 1'b1, st, 1'b0);
  endtask

  task automatic test_clean_line();
    stall_t st = '{default: 0};
    run_line("clean_line", 20'h12345, 6'h2A, 1'b0, st, 1'b0);
  endtask

  task automatic test_wait_states();
    stall_t st = '{default: 0};
    st[7] = 3;
    foreach (line_mem[k]) line_mem[k] = $urandom;
    run_line("wait_word7", 20'h0F0F0, 6'h11, 1'b1, st, 1'b0);
  endtask

  task automatic test_start_ignored();
    stall_t st = '{default: 0};
    foreach (line_mem[k]) line_mem[k] = $urandom;
    run_line("start_ignored", 20'h55AA5, 6'h3F, 1'b1, st, 1'b1);
  endtask

  task automatic test_back_to_back();
    stall_t st;
    for (int i = 0; i < 4; i++) begin
      foreach (st[k]) st[k] = int'($urandom_range(0, 2));
      foreach (line_mem[k]) line_mem[k] = $urandom;
      run_line($sformatf("random%0d", i), 20'($urandom), 6'($urandom),
               (i != 2), st, 1'b0);
    end
  endtask

  task automatic test_reset_mid_transfer();
    stall_t st = '{default: 0};
    int nacc;
    bit hit;
    nacc = 0; hit = 1'b0;
    foreach (line_mem[k]) line_mem[k] = $urandom;
    @(negedge clk);
    line_tag = 20'h13579; line_index = 6'h0C; line_dirty = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (avm_if.avm_write) begin
        if (nacc == 4) begin
          avm_if.avm_waitrequest = 1'b1;
          rst = 1'b1;
          hit = 1'b1;
          break;
        end
        avm_if.avm_waitrequest = 1'b0;
        nacc++;
      end
      @(negedge clk);
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL rst_mid reach_word4: got %0d accepted writes expected 4 then WRITE", nacc);
    end
    @(negedge clk);
    tests++;
    if (avm_if.avm_write !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid outputs: got write %b busy %b done %b expected 0 0 0",
               avm_if.avm_write, busy, done);
    end
    tests++;
    if (avm_if.avm_address !== 32'h0 || lkup_off !== 6'h0) begin
      fails++;
      $display("FAIL rst_mid address: got addr %h off %h expected 0 0",
               avm_if.avm_address, lkup_off);
    end
    rst = 1'b0;
    avm_if.avm_waitrequest = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if (done !== 1'b0 || avm_if.avm_write !== 1'b0) begin
        fails++;
        $display("FAIL rst_mid quiet c%0d: got done %b write %b expected 0 0",
                 c, done, avm_if.avm_write);
      end
    end
    run_line("after_reset", 20'h2468A, 6'h21, 1'b1, st, 1'b0);
  endtask

  initial begin
    test_reset();
    test_dirty_line();
    test_clean_line();
    test_wait_states();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_transfer();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_cache_writeback

// File: doc/cache_writeback.md
# cache_writeback

Write-back engine for one direct-mapped cache line. It sits between a cache line store and the Avalon-MM memory master. On request it reads a dirty line word by word through the store's lookup port and issues one single-word Avalon write per word to main memory. It then signals completion so the cache controller can refill or reuse the line.

## Interface
Parameters:
- CACHE_LINE_WIDTH, 6: log2 line size in bytes; words per line N = 2^(CACHE_LINE_WIDTH-2).
- TAG_WIDTH, 20: tag bits, taken from the top of the address.
- ADDR_WIDTH, 32: byte address width. INDEX_WIDTH = ADDR_WIDTH-TAG_WIDTH-CACHE_LINE_WIDTH, must be ≥1.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  write-back request; sampled only in IDLE.
- lineTag  in  TAG_WIDTH  tag of the line; captured on accepted start.
- lineIndex  in  INDEX_WIDTH  set index of the line; captured on accepted start.
- lineDirty  in  1  line dirty flag; captured on accepted start.
- busy  out  1  high from accepted start until done is asserted, inclusive.
- done  out  1  one-cycle completion pulse.
- lkupOff  out  CACHE_LINE_WIDTH  byte offset driven to the line store; always {wordCnt, 2'b00}.
- lkupData  in  32  combinational word returned by the line store for lkupOff.
- avm_address  out  ADDR_WIDTH  {tag, index, wordCnt, 2'b00}.
- avm_write  out  1  Avalon write request.
- avm_writedata  out  32  registered copy of lkupData.
- avm_byteenable  out  4  constant 4'b1111.
- avm_waitrequest  in  1  Avalon stall.
- clrDirty  out  1  one-cycle pulse; present only with WB_CLEAN_LINE_EN.
- clrTag  out  TAG_WIDTH  tag to rewrite with the clean line; present only with WB_CLEAN_LINE_EN.

## Operation
- State machine: IDLE, LOAD, WRITE, CLEAN (present only with the macro), DONE.
- IDLE:
  - start=1 and lineDirty=1: capture tag and index, set wordCnt=0, go to LOAD.
  - start=1 and lineDirty=0: go to DONE with no bus activity.
  - start=0: stay in IDLE.
- LOAD: register lkupData into avm_writedata and the address into avm_address, assert avm_write, go to WRITE.
- WRITE: hold avm_write, avm_address and avm_writedata stable while avm_waitrequest=1. On the first cycle with avm_waitrequest=0:
  - drop avm_write;
  - if wordCnt==N-1, go to CLEAN (or to DONE without the macro);
  - otherwise increment wordCnt and go to LOAD.
- wordCnt is CACHE_LINE_WIDTH-2 bits wide. It never wraps inside a transfer; the last word is detected explicitly.
- CLEAN: clrDirty=1 for one cycle with clrTag equal to the captured tag, then go to DONE.
- DONE: done=1 for one cycle, busy=1, then go to IDLE.
- start outside IDLE is ignored. Captured tag and index do not change mid-transfer.

## Timing
- Reset values:
  - state IDLE, wordCnt 0;
  - busy 0, done 0, avm_write 0, avm_address 0, avm_writedata 0, lkupOff 0, clrDirty 0, clrTag 0;
  - avm_byteenable 4'b1111.
- Words are issued strictly in order 0..N-1.
- With no wait states, each word takes 2 cycles (LOAD, WRITE). A dirty line completes with done at cycle 2N+1 after start, or 2N+2 with the macro.
- A clean line produces done exactly 1 cycle after start.
- Each wait-state cycle adds exactly one cycle.
- avm_write never deasserts while avm_waitrequest=1.
- rst mid-transfer: all outputs return to reset values on the next edge. The in-flight bus write is abandoned, and no done or clrDirty is issued.
- The line store must not be written while busy=1; the cache controller enforces this.

## Configuration
- WB_CLEAN_LINE_EN defined:
  - CLEAN state, clrDirty and clrTag are built in.
  - The top level turns clrDirty into a line write with byte enables 0, dirty 0, valid 1 and tag clrTag, leaving the line resident and clean.
- Not defined:
  - CLEAN, clrDirty and clrTag are absent; WRITE goes directly to DONE after the last word.
  - The controller invalidates or refills the line itself.

## Test plan
- Reset, then idle for 5 cycles: all outputs at reset values, avm_byteenable=4'hF, no done.
- Dirty line with defaults, tag 20'hABCDE, index 6'h05, words = offset*0x11111111, waitrequest=0: 16 writes at 0xABCDE140, 0xABCDE144, …, 0xABCDE17C with matching data; done at cycle 33 (34 with macro); clrDirty with clrTag=20'hABCDE one cycle before done.
- Clean line (lineDirty=0): done exactly 1 cycle after start; avm_write stays 0.
- waitrequest held high 3 cycles on word 7: address and data stable for 4 cycles; total latency +3; remaining words correct.
- start pulsed again during the transfer: ignored; exactly one done; 16 writes total.
- rst asserted in WRITE of word 4: next edge avm_write=0, busy=0, no done; a fresh start afterwards restarts at word 0.
